// File: rtl/hbus_lsu_master_pkg.sv
// Shared types for the XT high-speed bus load/store master: bus width codes,
// RISC-V funct3 encodings and the master's FSM states.
package XT_HBUS_Pkg;

    typedef enum logic [1:0] {
        HB_BYTE = 2'b00,
        HB_HALF = 2'b01,
        HB_WORD = 2'b10
    } hb_width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Only funct3[1:0] carries the size; funct3[2] is the unsigned flag for loads.
    function automatic hb_width_e hb_width_from_funct3(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return HB_BYTE;
            2'b01:   return HB_HALF;
            default: return HB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/hbus_lsu_master_formatter.sv
// Load data formatter: sign- or zero-extends the right-aligned slave read data
// according to the access width.
module hbus_load_formatter
    import XT_HBUS_Pkg::*;
(
    input  logic [31:0] raw_i,
    input  hb_width_e   width_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (width_i)
            HB_BYTE: data_o = {{24{raw_i[7] & ~unsigned_i}}, raw_i[7:0]};
            HB_HALF: data_o = {{16{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/hbus_lsu_master.sv
// XT bus load/store initiator: accepts one core request, drives the bus enable
// until the slave finishes, then returns done/err. Optional watchdog: HBUS_TIMEOUT_EN.
module hbus_lsu_master
    import XT_HBUS_Pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  hb_clk,
    input  logic                  rst,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [31:0]           lsu_wdata,
    output logic                  lsu_ready,
    output logic                  lsu_done,
    output logic [31:0]           lsu_rdata,
    output logic                  lsu_err,
    output logic [ADDR_WIDTH-1:0] hb_waddr,
    output logic [ADDR_WIDTH-1:0] hb_raddr,
    output logic [31:0]           hb_wdata,
    output logic [1:0]            hb_write_width,
    output logic                  hb_wen,
    output logic                  hb_ren,
    input  logic [31:0]           hb_rdata,
    input  logic                  hb_read_finish,
    input  logic                  hb_write_finish
);

    lsu_state_e            state_q;
    logic                  ready_q, done_q, err_q, wen_q, ren_q, unsigned_q;
    logic [31:0]           rdata_q, wdata_q;
    logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
    hb_width_e             wwidth_q, width_q;

    hb_width_e   req_width;
    logic        req_illegal, req_misalign;
    logic [31:0] fmt_data;

    assign req_width = hb_width_from_funct3(lsu_funct3);
    // Stores have no unsigned variants, so any funct3[2] store is illegal.
    assign req_illegal = lsu_we ? (lsu_funct3[2] || lsu_funct3[1:0] == 2'b11)
                                : (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11);
    assign req_misalign = (req_width == HB_HALF && lsu_addr[0]) ||
                          (req_width == HB_WORD && lsu_addr[1:0] != 2'b00);

    hbus_load_formatter u_fmt (
        .raw_i      (hb_rdata),
        .width_i    (width_q),
        .unsigned_i (unsigned_q),
        .data_o     (fmt_data)
    );

`ifdef HBUS_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    // The enable is high for exactly TIMEOUT_CYCLES cycles before giving up.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wwidth_q   <= HB_BYTE;
            width_q    <= HB_BYTE;
`ifdef HBUS_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu_req) begin
                        ready_q    <= 1'b0;
                        width_q    <= req_width;
                        unsigned_q <= lsu_funct3[2];
`ifdef HBUS_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                        if (req_illegal || req_misalign) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= ST_RESP;
                        end else if (lsu_we) begin
                            wen_q    <= 1'b1;
                            waddr_q  <= lsu_addr;
                            wdata_q  <= lsu_wdata;
                            wwidth_q <= req_width;
                            state_q  <= ST_WRITE;
                        end else begin
                            ren_q   <= 1'b1;
                            raddr_q <= lsu_addr;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (hb_read_finish) begin
                        ren_q   <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= fmt_data;
                        state_q <= ST_RESP;
                    end
`ifdef HBUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        ren_q   <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ST_WRITE: begin
                    if (hb_write_finish) begin
                        wen_q   <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_RESP;
                    end
`ifdef HBUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        wen_q   <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lsu_ready      = ready_q;
    assign lsu_done       = done_q;
    assign lsu_err        = err_q;
    assign lsu_rdata      = rdata_q;
    assign hb_wen         = wen_q;
    assign hb_ren         = ren_q;
    assign hb_waddr       = waddr_q;
    assign hb_raddr       = raddr_q;
    assign hb_wdata       = wdata_q;
    assign hb_write_width = wwidth_q;

endmodule
